// File: rtl/keypad_pkg.sv
// Shared types, scan constants and key decode for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] COL_INIT = 4'b0111;

    function automatic logic one_low(input logic [3:0] r);
        return (r == 4'b0111) || (r == 4'b1011) || (r == 4'b1101) || (r == 4'b1110);
    endfunction

    // Row patterns are listed top to bottom: 0111, 1011, 1101, 1110.
    function automatic key_code_t decode_key(input logic [3:0] r, input logic [3:0] c);
        key_code_t k;
        k = 4'h0;
        unique case (c)
            4'b0111: case (r)
                4'b0111: k = 4'hC;
                4'b1011: k = 4'hD;
                4'b1101: k = 4'hE;
                4'b1110: k = 4'hF;
                default: k = 4'h0;
            endcase
            4'b1011: case (r)
                4'b0111: k = 4'h3;
                4'b1011: k = 4'h6;
                4'b1101: k = 4'h9;
                4'b1110: k = 4'hB;
                default: k = 4'h0;
            endcase
            4'b1101: case (r)
                4'b0111: k = 4'h2;
                4'b1011: k = 4'h5;
                4'b1101: k = 4'h8;
                4'b1110: k = 4'h0;
                default: k = 4'h0;
            endcase
            4'b1110: case (r)
                4'b0111: k = 4'h1;
                4'b1011: k = 4'h4;
                4'b1101: k = 4'h7;
                4'b1110: k = 4'hA;
                default: k = 4'h0;
            endcase
            default: k = 4'h0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small FIFO for key events; pop on empty is ignored, push on full succeeds only with a same-cycle pop.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce and a key-event FIFO.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic                          slowclk,
    input  logic                          reset,
    input  logic [3:0]                    rows,
    output logic [3:0]                    cols,
    output logic                          key_valid,
    input  logic                          key_ready,
    output key_code_t                     key_code,
    output logic [$clog2(FIFO_DEPTH):0]   key_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam int         RPT_W   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cols, w_cols_nxt;
    logic [3:0]       r_latch, w_latch_nxt;
    logic [3:0]       r_dbc, w_dbc_nxt;
    logic [RPT_W-1:0] r_rpt, w_rpt_nxt;
    logic             r_push, w_push_nxt;
    key_code_t        r_push_code, w_code_nxt;
    logic             r_overflow;
    logic             w_rpt_fire;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

`ifdef KEYPAD_REPEAT_EN
    assign w_rpt_fire = (r_state == HELD) && (rows != 4'hF) && (r_rpt == RPT_LAST);
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cols_nxt  = r_cols;
        w_latch_nxt = r_latch;
        w_dbc_nxt   = r_dbc;
        w_rpt_nxt   = r_rpt;
        w_push_nxt  = 1'b0;
        w_code_nxt  = r_push_code;
        unique case (r_state)
            SCAN: begin
                if (one_low(rows)) begin
                    w_latch_nxt = rows;
                    w_dbc_nxt   = '0;
                    w_state_nxt = PRESS_DB;
                end else begin
                    w_cols_nxt = {r_cols[0], r_cols[3:1]};
                end
            end
            PRESS_DB: begin
                if (rows != r_latch) begin
                    w_state_nxt = SCAN;
                end else if (r_dbc == DB_LAST) begin
                    w_push_nxt  = 1'b1;
                    w_code_nxt  = decode_key(r_latch, r_cols);
                    w_dbc_nxt   = '0;
                    w_rpt_nxt   = '0;
                    w_state_nxt = HELD;
                end else begin
                    w_dbc_nxt = r_dbc + 1'b1;
                end
            end
            HELD: begin
                if (rows == 4'hF) begin
                    w_dbc_nxt   = '0;
                    w_rpt_nxt   = '0;
                    w_state_nxt = RELEASE_DB;
                end else if (w_rpt_fire) begin
                    w_push_nxt = 1'b1;
                    w_rpt_nxt  = '0;
                end else begin
                    w_rpt_nxt = (r_rpt == RPT_LAST) ? '0 : r_rpt + 1'b1;
                end
            end
            RELEASE_DB: begin
                if (rows != 4'hF) begin
                    w_state_nxt = HELD;
                end else if (r_dbc == DB_LAST) begin
                    w_dbc_nxt   = '0;
                    w_state_nxt = SCAN;
                end else begin
                    w_dbc_nxt = r_dbc + 1'b1;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    // Push is registered, so an accepted key lands in the FIFO one edge after debounce completes.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            r_state    <= SCAN;
            r_cols     <= COL_INIT;
            r_dbc      <= '0;
            r_rpt      <= '0;
            r_push     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cols  <= w_cols_nxt;
            r_dbc   <= w_dbc_nxt;
            r_rpt   <= w_rpt_nxt;
            r_push  <= w_push_nxt;
            if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (clr_overflow)          r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge slowclk) begin
        r_latch     <= w_latch_nxt;
        r_push_code <= w_code_nxt;
    end

    assign w_pop = key_valid & key_ready;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (4)
    ) u_fifo (
        .clk     (slowclk),
        .reset   (reset),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_data  (r_push_code),
        .o_data  (key_code),
        .o_count (key_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign key_valid = ~w_empty;
    assign cols      = r_cols;
    assign overflow  = r_overflow;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive stable samples required to accept a press or a release (legal range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the key-event buffer depth (power of two, 2..16).
REQ-003 Parameter REPEAT_CYCLES, default 64, SHALL set the auto-repeat interval in slowclk cycles (used only under KEYPAD_REPEAT_EN).
REQ-004 slowclk  in  1  scan clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rows  in  4  keypad rows, active-low.
REQ-007 cols  out  4  column drive, active-low, exactly one bit low.
REQ-008 key_valid  out  1  buffer non-empty; key_code is valid.
REQ-009 key_ready  in  1  consumer accepts key_code on key_valid & key_ready.
REQ-010 key_code  out  4  hex code at the buffer head.
REQ-011 key_count  out  $clog2(FIFO_DEPTH)+1  number of buffered events.
REQ-012 overflow  out  1  sticky flag: an event was dropped because the buffer was full.
REQ-013 clr_overflow  in  1  synchronous clear of overflow.

Function
REQ-014 FSM states SHALL be SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-015 In SCAN with rows==4'b1111, cols SHALL rotate right one position per cycle: 0111->1011->1101->1110->0111.
REQ-016 In SCAN, rows with exactly one bit low SHALL latch {rows,cols}, freeze cols, clear the debounce counter and enter PRESS_DB.
REQ-017 In SCAN, rows with two or more bits low SHALL be ignored; cols keep rotating.
REQ-018 In PRESS_DB, any rows value differing from the latched value SHALL return the FSM to SCAN with no event; cols resume rotation from the frozen value.
REQ-019 In PRESS_DB, after DEBOUNCE_CYCLES matching samples the FSM SHALL push the decoded code and enter HELD; with an empty buffer, key_valid SHALL rise DEBOUNCE_CYCLES+1 edges after the detecting edge.
REQ-020 Decode, listed as cols: rows 0111/1011/1101/1110 -> codes, SHALL be: 0111: C,D,E,F; 1011: 3,6,9,B; 1101: 2,5,8,0; 1110: 1,4,7,A.
REQ-021 In HELD, cols SHALL stay frozen; rows==4'b1111 SHALL clear the counter and enter RELEASE_DB.
REQ-022 In RELEASE_DB, DEBOUNCE_CYCLES consecutive all-high samples SHALL enter SCAN; any low row SHALL return to HELD with no new event.
REQ-023 The buffer SHALL be FIFO ordered; key_code SHALL be the head entry; a pop SHALL occur on key_valid & key_ready.
REQ-024 Push with the buffer full and no pop in the same cycle SHALL drop the event and set overflow; push and pop in the same cycle when full SHALL both succeed without setting overflow.
REQ-025 clr_overflow SHALL clear overflow; a same-cycle new overflow event SHALL win and leave it set.
REQ-026 Pop with the buffer empty SHALL have no effect; key_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 While reset is asserted: state=SCAN, cols=4'b0111, buffer empty, key_valid=0, key_code=4'h0, key_count=0, overflow=0, counters=0.
REQ-028 Reset asserted mid-debounce or while HELD SHALL discard the pending key; a key still held after reset SHALL be re-detected through SCAN.

Configuration
REQ-029 With KEYPAD_REPEAT_EN defined, HELD SHALL push the latched code again every REPEAT_CYCLES cycles while the key remains held; without it, each press SHALL produce exactly one event.

Structure
REQ-030 Package keypad_pkg SHALL hold the state enum, the key_code_t 4-bit typedef, COL_INIT=4'b0111 and the decode function.
REQ-031 The buffer SHALL be the sub-module key_fifo (push, pop, data, count, full, empty); the FSM, scan and debounce logic SHALL live in keypad_scan_ctrl.

Verification
REQ-032 Press row 2 (rows=1101) while cols=1011, held 10 cycles, key_ready=1 -> one event 4'h9; key_valid high for exactly 1 cycle.
REQ-033 Bounce: rows low 2 cycles, high 1, then low steady (DEBOUNCE_CYCLES=4) -> no event from the bounce; one event after 4 stable samples.
REQ-034 key_ready=0; press 5 distinct keys (1,2,3,A,0) -> key_count=4, overflow=1; drain yields 1,2,3,A in order.
REQ-035 Buffer full with key_valid & key_ready at the same cycle as a new push -> key_count stays 4, overflow stays 0.
REQ-036 Two rows low on one column -> no event, cols keep rotating; reset during PRESS_DB -> cols=0111, key_count=0.
REQ-037 KEYPAD_REPEAT_EN defined, REPEAT_CYCLES=8, key 4'h5 held 30 cycles past acceptance -> 4 events of 4'h5; undefined -> 1 event.
